hmac_sha256_ctrl: RTL

Sequencer that computes a single-message HMAC-SHA256 by time-sharing one SHA-256 compression core across the four compressions HMAC requires. It sits between the host-side key/message registers and the compression datapath (round engine plus final H-addition). It drives the core's block, initial-hash and start inputs, and collects its digests. It owns the ipad/opad construction, the chaining between compressions, and the outer-hash padding.

---
 rtl/hmac_sha256_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hmac_sha256_ctrl.sv
// rtl/hmac_sha256_ctrl.sv - HMAC-SHA256 sequencer time-sharing one compression core
// Runs inner (ipad, msg) then outer (opad, padded inner digest) compressions in turn.
module hmac_sha256_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] key,
    input  logic [511:0] msg_block,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [255:0] mac,
    output logic         core_start,
    output logic [255:0] core_hin,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_digest
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] IPAD = {64{8'h36}};
    localparam logic [511:0] OPAD = {64{8'h5c}};

    typedef enum logic [3:0] {
        IDLE, ISSUE_I1, WAIT_I1, ISSUE_I2, WAIT_I2,
        ISSUE_O1, WAIT_O1, ISSUE_O2, WAIT_O2, FINISH
    } state_t;

    state_t         state;
    logic [511:0]   key_q;
    logic [511:0]   msg_q;
    logic [255:0]   inner_q;
    logic [CW-1:0]  wait_cnt;
    logic           expire;

    // Timeout wins over a core_done landing on the last permitted wait cycle.
    assign expire = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_q      <= '0;
            msg_q      <= '0;
            inner_q    <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mac        <= '0;
            core_start <= 1'b0;
            core_hin   <= '0;
            core_block <= '0;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            key_q      <= key;
                            msg_q      <= msg_block;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            core_start <= 1'b1;
                            core_hin   <= SHA_IV;
                            core_block <= key ^ IPAD;
                            state      <= ISSUE_I1;
                        end
                    end
                    ISSUE_I1: begin
                        wait_cnt <= '0;
                        state    <= WAIT_I1;
                    end
                    ISSUE_I2: begin
                        wait_cnt <= '0;
                        state    <= WAIT_I2;
                    end
                    ISSUE_O1: begin
                        wait_cnt <= '0;
                        state    <= WAIT_O1;
                    end
                    ISSUE_O2: begin
                        wait_cnt <= '0;
                        state    <= WAIT_O2;
                    end
                    WAIT_I1, WAIT_I2, WAIT_O1, WAIT_O2: begin
                        if (expire) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (!core_done) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end else begin
                            case (state)
                                WAIT_I1: begin
                                    core_hin   <= core_digest;
                                    core_block <= msg_q;
                                    core_start <= 1'b1;
                                    state      <= ISSUE_I2;
                                end
                                WAIT_I2: begin
                                    inner_q    <= core_digest;
                                    core_hin   <= SHA_IV;
                                    core_block <= key_q ^ OPAD;
                                    core_start <= 1'b1;
                                    state      <= ISSUE_O1;
                                end
                                WAIT_O1: begin
                                    // Outer message is one 32-byte digest after a 64-byte key block.
                                    core_hin   <= core_digest;
                                    core_block <= {inner_q, 8'h80, 184'd0, 64'd768};
                                    core_start <= 1'b1;
                                    state      <= ISSUE_O2;
                                end
                                default: begin
                                    mac   <= core_digest;
                                    done  <= 1'b1;
                                    state <= FINISH;
                                end
                            endcase
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
